// File: rtl/display_mixer_pkg.sv
// display_mixer_pkg: shared types and constants for the display mixer.
// Holds the display mode encoding, the enable FSM state encoding and the
// colour-bar palette used by the optional test pattern
// (DISPLAY_MIXER_PATTERN_EN).
package display_mixer_pkg;

    typedef enum logic [1:0] {
        MODE_GRAY    = 2'd0,
        MODE_EDGE    = 2'd1,
        MODE_OVERLAY = 2'd2,
        MODE_SPLIT   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } en_state_t;

    localparam logic [23:0] RGB_BLACK = 24'h000000;
    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;

    // Classic 8-bar palette, left to right.
    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: resettable shift register of DEPTH stages, WIDTH bits wide.
// Used to align sync/enable with the framebuffer read latency.
module sync_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             pix_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per pixel clock; reset clears every stage.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/display_mixer.sv
// display_mixer: composites a grayscale layer and a binary edge layer into
// 24-bit RGB in one of four modes. Timing is delayed to match the framebuffer
// read latency, the mode changes only on frame boundaries, and video stays
// blank until both layers hold a complete frame.
// Optional: DISPLAY_MIXER_PATTERN_EN shows colour bars while not active.
module display_mixer
    import display_mixer_pkg::*;
#(
    parameter int          DATA_W = 8,
    parameter int          H_RES  = 640,
    parameter int          RD_LAT = 1,
    parameter logic [7:0]  OVL_R  = 8'hFF,
    parameter logic [7:0]  OVL_G  = 8'h00,
    parameter logic [7:0]  OVL_B  = 8'h00
) (
    input  logic              pix_clk,
    input  logic              async_rst_n,
    input  logic [1:0]        mode_async_i,
    input  logic              hs_i,
    input  logic              vs_i,
    input  logic              de_i,
    input  logic              frame_i,
    input  logic [DATA_W-1:0] gray_i,
    input  logic              edge_i,
    input  logic              gray_rdy_i,
    input  logic              edge_rdy_i,
    output logic              hs_o,
    output logic              vs_o,
    output logic              de_o,
    output logic [7:0]        red_o,
    output logic [7:0]        green_o,
    output logic [7:0]        blue_o,
    output logic [1:0]        mode_o,
    output logic              active_o,
    output logic [1:0]        fsm_state
);

    localparam int               COL_W    = $clog2(H_RES);
    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(H_RES - 1);
    localparam logic [COL_W-1:0] COL_HALF = COL_W'(H_RES / 2);
    localparam logic [23:0]      OVL_RGB  = {OVL_R, OVL_G, OVL_B};

    logic              rst_meta, rst_n;
    logic [1:0]        mode_meta, mode_req;
    mode_t             mode_q;
    en_state_t         state, state_nx;
    logic              both_rdy;
    logic              hs_d, vs_d, de_d;
    logic [COL_W-1:0]  col;
    logic [7:0]        gray8;
    logic [23:0]       gray_px, edge_px, pix;
    logic              hs_q, vs_q, de_q;
    logic [23:0]       rgb_q, rgb_out;
    logic              unused_gray;

    // Reset synchronizer: asserts immediately, releases on the 2nd clock edge.
    always_ff @(posedge pix_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    // Mode switches: 2-flop synchronizer, applied only on a frame boundary.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_meta <= 2'd0;
            mode_req  <= 2'd0;
            mode_q    <= MODE_GRAY;
        end else begin
            mode_meta <= mode_async_i;
            mode_req  <= mode_meta;
            if (frame_i) mode_q <= mode_t'(mode_req);
        end
    end

    assign both_rdy = gray_rdy_i & edge_rdy_i;

    // Enable FSM state register.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Enable FSM next state: arm once both layers are ready, run from the
    // next frame start, drop out immediately if either layer goes away.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (both_rdy) state_nx = ST_ARM;
            ST_ARM: begin
                if (!both_rdy)    state_nx = ST_IDLE;
                else if (frame_i) state_nx = ST_RUN;
            end
            ST_RUN:  if (!both_rdy) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign active_o  = (state == ST_RUN);
    assign fsm_state = state;
    assign mode_o    = mode_q;

    sync_delay_line #(
        .WIDTH (3),
        .DEPTH (RD_LAT)
    ) u_delay (
        .pix_clk (pix_clk),
        .rst_n   (rst_n),
        .din     ({hs_i, vs_i, de_i}),
        .dout    ({hs_d, vs_d, de_d})
    );

    // Column of the aligned pixel: counts along the delayed enable, saturating.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n)            col <= '0;
        else if (!de_d)        col <= '0;
        else if (col != COL_MAX) col <= col + COL_W'(1);
    end

    assign gray8       = gray_i[DATA_W-1 -: 8];
    assign unused_gray = ^gray_i;

    // Pixel compositing for the currently applied mode.
    always_comb begin
        gray_px = {gray8, gray8, gray8};
        edge_px = edge_i ? RGB_BLACK : RGB_WHITE;
        pix     = gray_px;
        case (mode_q)
            MODE_GRAY:    pix = gray_px;
            MODE_EDGE:    pix = edge_px;
            MODE_OVERLAY: pix = edge_i ? OVL_RGB : gray_px;
            MODE_SPLIT:   pix = (col < COL_HALF) ? gray_px : edge_px;
            default:      pix = gray_px;
        endcase
    end

    // Output register: aligned timing and composited pixel (black outside de).
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            de_q  <= 1'b0;
            rgb_q <= RGB_BLACK;
        end else begin
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            rgb_q <= de_d ? pix : RGB_BLACK;
        end
    end

`ifdef DISPLAY_MIXER_PATTERN_EN
    localparam int BAR_W = H_RES / 8;
    logic [2:0]  bar_idx;
    logic [23:0] pat_q;

    assign bar_idx = 3'(32'(col) / BAR_W);

    // Colour-bar pattern shown while the layers are not yet running.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) pat_q <= RGB_BLACK;
        else        pat_q <= de_d ? bar_rgb(bar_idx) : RGB_BLACK;
    end

    assign rgb_out = active_o ? rgb_q : pat_q;
    assign de_o    = de_q;
`else
    assign rgb_out = active_o ? rgb_q : RGB_BLACK;
    assign de_o    = de_q & active_o;
`endif

    assign hs_o    = hs_q;
    assign vs_o    = vs_q;
    assign red_o   = rgb_out[23:16];
    assign green_o = rgb_out[15:8];
    assign blue_o  = rgb_out[7:0];

endmodule

// File: tb/tb_display_mixer.sv
// tb_display_mixer: randomized bench for display_mixer with a behavioural
// reference model built from input history and the mode/enable rules.
module tb_display_mixer;
    import display_mixer_pkg::*;

    localparam int DATA_W  = 10;
    localparam int H_RES   = 64;
    localparam int RD_LAT  = 2;
    localparam int H_TOTAL = 80;
    localparam int HS_BEG  = 68;
    localparam int HS_END  = 76;
    localparam int V_ACT   = 6;
    localparam int V_TOTAL = 8;
    localparam int VS_LINE = 7;
    localparam int FRAME   = H_TOTAL * V_TOTAL;

    // ---------------- clock / reset / DUT ----------------
    logic              pix_clk = 1'b0;
    logic              async_rst_n;
    logic [1:0]        mode_async_i;
    logic              hs_i, vs_i, de_i, frame_i;
    logic [DATA_W-1:0] gray_i;
    logic              edge_i, gray_rdy_i, edge_rdy_i;
    logic              hs_o, vs_o, de_o, active_o;
    logic [7:0]        red_o, green_o, blue_o;
    logic [1:0]        mode_o, fsm_state;

    always #5 pix_clk = ~pix_clk;

    display_mixer #(
        .DATA_W (DATA_W),
        .H_RES  (H_RES),
        .RD_LAT (RD_LAT)
    ) dut (
        .pix_clk      (pix_clk),
        .async_rst_n  (async_rst_n),
        .mode_async_i (mode_async_i),
        .hs_i         (hs_i),
        .vs_i         (vs_i),
        .de_i         (de_i),
        .frame_i      (frame_i),
        .gray_i       (gray_i),
        .edge_i       (edge_i),
        .gray_rdy_i   (gray_rdy_i),
        .edge_rdy_i   (edge_rdy_i),
        .hs_o         (hs_o),
        .vs_o         (vs_o),
        .de_o         (de_o),
        .red_o        (red_o),
        .green_o      (green_o),
        .blue_o       (blue_o),
        .mode_o       (mode_o),
        .active_o     (active_o),
        .fsm_state    (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic        hs_h [8];
    logic        vs_h [8];
    logic        de_h [8];
    int          col_h [8];
    int          m_mode, m_req1, m_req2;
    bit          m_run, m_armed;
    int          hc, vc;
    bit          directed;
    logic        exp_hs, exp_vs, exp_de;
    logic [23:0] exp_rgb;

    function automatic logic [23:0] ref_pixel(input int mode, input logic [DATA_W-1:0] g,
                                              input logic e, input int col);
        logic [7:0]  g8;
        logic [23:0] gp, ep;
        g8 = g[DATA_W-1 -: 8];
        gp = {g8, g8, g8};
        ep = e ? 24'h000000 : 24'hFFFFFF;
        case (mode)
            0:       return gp;
            1:       return ep;
            2:       return e ? 24'hFF0000 : gp;
            default: return (col < H_RES / 2) ? gp : ep;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            hs_h[i] = 1'b0; vs_h[i] = 1'b0; de_h[i] = 1'b0; col_h[i] = 0;
        end
        m_mode = 0; m_req1 = 0; m_req2 = 0;
        m_run = 1'b0; m_armed = 1'b0;
        hc = 0; vc = 0;
    endtask

    // What the outputs must be after the clock edge that just sampled the inputs.
    task automatic model_edge();
        int  mode_used, col;
        bit  both;
        for (int i = 7; i > 0; i--) begin
            hs_h[i] = hs_h[i-1]; vs_h[i] = vs_h[i-1];
            de_h[i] = de_h[i-1]; col_h[i] = col_h[i-1];
        end
        hs_h[0] = hs_i; vs_h[0] = vs_i; de_h[0] = de_i; col_h[0] = hc;
        mode_used = m_mode;
        if (frame_i) m_mode = m_req2;
        m_req2 = m_req1;
        m_req1 = int'(mode_async_i);
        both = gray_rdy_i && edge_rdy_i;
        if (!both) begin
            m_run = 1'b0; m_armed = 1'b0;
        end else if (!m_run) begin
            if (m_armed && frame_i) begin m_run = 1'b1; m_armed = 1'b0; end
            else m_armed = 1'b1;
        end
        col     = (col_h[RD_LAT] > H_RES - 1) ? H_RES - 1 : col_h[RD_LAT];
        exp_hs  = hs_h[RD_LAT];
        exp_vs  = vs_h[RD_LAT];
        exp_de  = de_h[RD_LAT] && m_run;
        exp_rgb = exp_de ? ref_pixel(mode_used, gray_i, edge_i, col) : 24'h0;
    endtask

    task automatic compare_outputs();
        logic [1:0] exp_state;
        exp_state = m_run ? ST_RUN : (m_armed ? ST_ARM : ST_IDLE);
        check("hs_o", hs_o, exp_hs);
        check("vs_o", vs_o, exp_vs);
        check("de_o", de_o, exp_de);
        check("rgb", {red_o, green_o, blue_o}, exp_rgb);
        check("mode_o", mode_o, m_mode);
        check("active_o", active_o, m_run);
        check("fsm_state", fsm_state, exp_state);
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drive one pixel cycle, model the rising edge,
    // then compare at the next falling edge.
    task automatic step();
        hs_i    = (hc >= HS_BEG && hc < HS_END);
        vs_i    = (vc == VS_LINE);
        de_i    = (hc < H_RES && vc < V_ACT);
        frame_i = (vc == V_TOTAL - 1 && hc == H_TOTAL - 1);
        if (directed) begin
            gray_i = DATA_W'(10'h100);
            edge_i = ~edge_i;
        end else begin
            gray_i = DATA_W'($urandom);
            edge_i = 1'($urandom_range(0, 1));
        end
        @(posedge pix_clk);
        model_edge();
        if (hc == H_TOTAL - 1) begin
            hc = 0;
            vc = (vc == V_TOTAL - 1) ? 0 : vc + 1;
        end else begin
            hc++;
        end
        @(negedge pix_clk);
        compare_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_to_frame();
        for (int i = 0; i < FRAME && !(vc == V_TOTAL - 1 && hc == H_TOTAL - 1); i++) step();
    endtask

    task automatic zero_inputs();
        hs_i = 1'b0; vs_i = 1'b0; de_i = 1'b0; frame_i = 1'b0;
        gray_i = '0; edge_i = 1'b0; gray_rdy_i = 1'b0; edge_rdy_i = 1'b0;
        mode_async_i = 2'd0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hs"}, hs_o, 1'b0);
        check({tag, "_vs"}, vs_o, 1'b0);
        check({tag, "_de"}, de_o, 1'b0);
        check({tag, "_rgb"}, {red_o, green_o, blue_o}, 24'h0);
        check({tag, "_mode"}, mode_o, 2'd0);
        check({tag, "_active"}, active_o, 1'b0);
        check({tag, "_state"}, fsm_state, ST_IDLE);
    endtask

    // ---------------- stimulus ----------------
    int mode_seq [5] = '{1, 0, 2, 3, 1};

    initial begin
        directed = 1'b0;
        async_rst_n = 1'b0;
        zero_inputs();
        repeat (3) @(negedge pix_clk);
        check_reset_values("reset");
        async_rst_n = 1'b1;
        repeat (6) @(negedge pix_clk);
        model_reset();

        // Layers not ready: blank output, timing still runs.
        run(FRAME);

        // Both layers become ready mid-frame; video starts after next frame_i.
        run(300);
        gray_rdy_i = 1'b1; edge_rdy_i = 1'b1;
        run(2 * FRAME);

        // Overlay with fixed gray and alternating edges, then split screen.
        directed = 1'b1;
        mode_async_i = 2'd2;
        run(2 * FRAME);
        run(200);
        mode_async_i = 2'd3;
        run(2 * FRAME);
        directed = 1'b0;

        // Mode changes at random points mid-frame.
        foreach (mode_seq[i]) begin
            run($urandom_range(50, 600));
            mode_async_i = 2'(mode_seq[i]);
            run(FRAME);
        end

        // Edge layer drops while running, then returns.
        run(150);
        edge_rdy_i = 1'b0;
        run(3);
        edge_rdy_i = 1'b1;
        run(2 * FRAME);

        // Readiness lost in the same cycle as frame_i while armed.
        edge_rdy_i = 1'b0;
        step();
        edge_rdy_i = 1'b1;
        run_to_frame();
        edge_rdy_i = 1'b0;
        step();
        edge_rdy_i = 1'b1;
        run(2 * FRAME);

        // Random modes with occasional readiness glitches.
        repeat (8 * FRAME) begin
            if ($urandom_range(0, 299) == 0) mode_async_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) gray_rdy_i = 1'b0;
            else if (!gray_rdy_i && $urandom_range(0, 29) == 0) gray_rdy_i = 1'b1;
            if ($urandom_range(0, 999) == 0) edge_rdy_i = 1'b0;
            else if (!edge_rdy_i && $urandom_range(0, 29) == 0) edge_rdy_i = 1'b1;
            step();
        end

        // Asynchronous reset in the middle of a running frame.
        gray_rdy_i = 1'b1; edge_rdy_i = 1'b1;
        mode_async_i = 2'd2;
        run(2 * FRAME + 200);
        async_rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge pix_clk);
        zero_inputs();
        async_rst_n = 1'b1;
        repeat (6) @(negedge pix_clk);
        model_reset();
        gray_rdy_i = 1'b1; edge_rdy_i = 1'b1;
        mode_async_i = 2'd3;
        run(3 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
